// File: rtl/cgra_cfg_pkg.sv
// Shared definitions for the CGRA configuration sequencer and any future
// readback/monitor logic that needs to decode its state.
package cgra_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CGRA_RST = 3'd1,
        LOAD     = 3'd2,
        SETTLE   = 3'd3,
        RUN      = 3'd4,
        DONE     = 3'd5
    } cfg_state_e;

    // Address value the CGRA interprets as "no configuration write".
    localparam int CFG_NOP_ADDR = 0;

    localparam int CFG_ADDR_W = 32;
    localparam int CFG_DATA_W = 32;
    localparam int CFG_CNT_W  = 32;

    function automatic int cfg_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cfg_down_counter.sv
// Loadable down counter with a zero flag. Load wins over decrement, and the
// count parks at zero instead of wrapping.
module cfg_down_counter #(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         reset_in,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Load a new terminal count or step toward zero.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/cgra_config_sequencer.sv
// Host-side controller for the CGRA config port: resets the array, streams a
// bitstream onto the config bus one word per cycle, lets the bus settle, runs
// the array for a programmed number of cycles and reports completion.
module cgra_config_sequencer
    import cgra_cfg_pkg::*;
#(
    parameter int ADDR_W        = CFG_ADDR_W,
    parameter int DATA_W        = CFG_DATA_W,
    parameter int CNT_W         = CFG_CNT_W,
    parameter int RST_CYCLES    = 3,
    parameter int SETTLE_CYCLES = 2,
    parameter int LOAD_TIMEOUT  = 1024
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              start_in,
    input  logic              abort_in,
    input  logic [CNT_W-1:0]  max_cycles_in,
    input  logic              cfg_valid_in,
    output logic              cfg_ready_out,
    input  logic [ADDR_W-1:0] cfg_addr_in,
    input  logic [DATA_W-1:0] cfg_data_in,
    input  logic              cfg_last_in,
    output logic              cgra_reset_out,
    output logic [ADDR_W-1:0] config_addr_out,
    output logic [DATA_W-1:0] config_data_out,
    output logic              run_out,
    output logic [CNT_W-1:0]  cycle_count_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              error_out
);

    // One shared counter times reset, settle and the load stall, so it must
    // hold the largest of the three terminal counts.
    localparam int DC_W = $clog2(cfg_max3(RST_CYCLES, SETTLE_CYCLES, LOAD_TIMEOUT) + 1);

    cfg_state_e        r_state;
    logic              r_cgra_rst;
    logic              r_run;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_max;

    logic              w_xfer;
    logic              w_dc_zero;
    logic              w_dc_load;
    logic              w_dc_dec;
    logic [DC_W-1:0]   w_dc_val;
    logic [CNT_W-1:0]  w_count_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] res;
        if (v == '1) begin
            res = v;
        end else begin
            res = v + CNT_W'(1);
        end
        return res;
    endfunction

    // Ready is a pure state decode so the host never sees it depend on valid.
    assign cfg_ready_out = (r_state == LOAD);
    assign w_xfer        = cfg_valid_in && (r_state == LOAD);
    assign w_count_inc   = sat_inc(r_count);

    // Counter loads: RST_CYCLES-1 at start, LOAD_TIMEOUT-1 on entering LOAD and
    // after every word, SETTLE_CYCLES after the last word (the first SETTLE
    // cycle still shows that word on the bus, the rest are NOPs).
    always_comb begin
        w_dc_load = 1'b0;
        w_dc_dec  = 1'b0;
        w_dc_val  = '0;
        if (!abort_in) begin
            case (r_state)
                IDLE: begin
                    if (start_in) begin
                        w_dc_load = 1'b1;
                        w_dc_val  = DC_W'(RST_CYCLES - 1);
                    end
                end
                CGRA_RST: begin
                    if (w_dc_zero) begin
                        w_dc_load = 1'b1;
                        w_dc_val  = DC_W'(LOAD_TIMEOUT - 1);
                    end else begin
                        w_dc_dec = 1'b1;
                    end
                end
                LOAD: begin
                    if (w_xfer) begin
                        w_dc_load = 1'b1;
                        w_dc_val  = cfg_last_in ? DC_W'(SETTLE_CYCLES) : DC_W'(LOAD_TIMEOUT - 1);
                    end else begin
                        w_dc_dec = 1'b1;
                    end
                end
                SETTLE: w_dc_dec = 1'b1;
                default: ;
            endcase
        end
    end

    cfg_down_counter #(
        .W(DC_W)
    ) u_down_counter (
        .clk_in     (clk_in),
        .reset_in   (reset_in),
        .i_load     (w_dc_load),
        .i_load_val (w_dc_val),
        .i_dec      (w_dc_dec),
        .o_zero     (w_dc_zero)
    );

    // Sequencer FSM with every output registered alongside the state.
    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            r_state    <= IDLE;
            r_cgra_rst <= 1'b0;
            r_run      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_count    <= '0;
            r_max      <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort_in) begin
                // Drop everything driving the array; count and error are kept
                // so the host can inspect how far it got.
                r_state    <= IDLE;
                r_cgra_rst <= 1'b0;
                r_run      <= 1'b0;
                r_busy     <= 1'b0;
                r_addr     <= ADDR_W'(CFG_NOP_ADDR);
                r_data     <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start_in) begin
                            r_state    <= CGRA_RST;
                            r_max      <= max_cycles_in;
                            r_count    <= '0;
                            r_error    <= 1'b0;
                            r_cgra_rst <= 1'b1;
                            r_busy     <= 1'b1;
                        end
                    end
                    CGRA_RST: begin
                        if (w_dc_zero) begin
                            r_state    <= LOAD;
                            r_cgra_rst <= 1'b0;
                        end
                    end
                    LOAD: begin
                        if (w_xfer) begin
                            r_addr <= cfg_addr_in;
                            r_data <= cfg_data_in;
                            if (cfg_last_in) begin
                                r_state <= SETTLE;
                            end
                        end else begin
                            r_addr <= ADDR_W'(CFG_NOP_ADDR);
                            r_data <= '0;
                            if (w_dc_zero) begin
                                r_error <= 1'b1;
                                r_done  <= 1'b1;
                                r_state <= DONE;
                            end
                        end
                    end
                    SETTLE: begin
                        r_addr <= ADDR_W'(CFG_NOP_ADDR);
                        r_data <= '0;
                        if (w_dc_zero) begin
                            if (r_max == '0) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= RUN;
                                r_run   <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        r_count <= w_count_inc;
                        if (w_count_inc == r_max) begin
                            r_state <= DONE;
                            r_run   <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cgra_reset_out  = r_cgra_rst;
    assign config_addr_out = r_addr;
    assign config_data_out = r_data;
    assign run_out         = r_run;
    assign cycle_count_out = r_count;
    assign busy_out        = r_busy;
    assign done_out        = r_done;
    assign error_out       = r_error;

endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Bench for cgra_config_sequencer: table of sequences (plus random rows)
// checked cycle by cycle against a timeline computed from the sequencing
// rules, and hand-written checks for reset and idle-state corner cases.
module tb_cgra_config_sequencer;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int CNT_W    = 8;
    localparam int RST_C    = 3;
    localparam int SETTLE_C = 2;
    localparam int TOUT     = 16;

    logic              clk_in = 1'b0;
    logic              reset_in;
    logic              start_in;
    logic              abort_in;
    logic [CNT_W-1:0]  max_cycles_in;
    logic              cfg_valid_in;
    logic              cfg_ready_out;
    logic [ADDR_W-1:0] cfg_addr_in;
    logic [DATA_W-1:0] cfg_data_in;
    logic              cfg_last_in;
    logic              cgra_reset_out;
    logic [ADDR_W-1:0] config_addr_out;
    logic [DATA_W-1:0] config_data_out;
    logic              run_out;
    logic [CNT_W-1:0]  cycle_count_out;
    logic              busy_out;
    logic              done_out;
    logic              error_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    cgra_config_sequencer #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .CNT_W         (CNT_W),
        .RST_CYCLES    (RST_C),
        .SETTLE_CYCLES (SETTLE_C),
        .LOAD_TIMEOUT  (TOUT)
    ) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .start_in        (start_in),
        .abort_in        (abort_in),
        .max_cycles_in   (max_cycles_in),
        .cfg_valid_in    (cfg_valid_in),
        .cfg_ready_out   (cfg_ready_out),
        .cfg_addr_in     (cfg_addr_in),
        .cfg_data_in     (cfg_data_in),
        .cfg_last_in     (cfg_last_in),
        .cgra_reset_out  (cgra_reset_out),
        .config_addr_out (config_addr_out),
        .config_data_out (config_data_out),
        .run_out         (run_out),
        .cycle_count_out (cycle_count_out),
        .busy_out        (busy_out),
        .done_out        (done_out),
        .error_out       (error_out)
    );

    typedef struct {
        logic              rst;
        logic              ready;
        logic              run;
        logic              busy;
        logic              done;
        logic              err;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    // One sequence: stimulus shape plus the whole-sequence results it must give.
    typedef struct {
        int nw;         // words in the bitstream
        int gapmax;     // max idle cycles before each word
        bit last;       // 1: final word carries cfg_last, 0: stall into timeout
        int maxc;       // RUN length
        int abort_at;   // absolute cycle of abort, -1 none
        int abort_run;  // abort at this RUN cycle offset, -1 none
        int exp_rst;    // cycles with cgra_reset_out high
        int exp_run;    // cycles with run_out high
        int exp_done;   // done pulses
        bit exp_err;    // error_out afterwards
        int exp_cnt;    // cycle_count_out afterwards
    } vec_t;

    // Timeline of the current sequence; cycle 0 is the cycle after start is taken.
    int                m_xc[$];
    logic [ADDR_W-1:0] m_addr[$];
    logic [DATA_W-1:0] m_data[$];
    int                m_tlast;
    int                m_r0;
    int                m_dd;
    int                m_tend;
    int                m_M;
    bit                m_timeout;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic exp_t model_at(input int c);
        exp_t e;
        e.rst   = (c >= 0) && (c < RST_C);
        e.ready = 1'b0;
        e.run   = 1'b0;
        e.busy  = (c >= 0) && (c <= m_dd);
        e.done  = (c == m_dd);
        e.err   = 1'b0;
        e.cnt   = '0;
        e.addr  = '0;
        e.data  = '0;
        if (m_timeout) begin
            e.ready = (c >= RST_C) && (c <= m_tend);
            e.err   = (c >= m_dd);
        end else begin
            e.ready = (c >= RST_C) && (c <= m_tlast);
            e.run   = (c >= m_r0) && (c < m_dd);
            if (c < m_r0)      e.cnt = '0;
            else if (c < m_dd) e.cnt = CNT_W'(c - m_r0);
            else               e.cnt = CNT_W'(m_M);
        end
        foreach (m_xc[i]) begin
            if (m_xc[i] + 1 == c) begin
                e.addr = m_addr[i];
                e.data = m_data[i];
            end
        end
        return e;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, ".cgra_reset"}, 64'(cgra_reset_out), 64'(e.rst));
        chk({tag, ".ready"},      64'(cfg_ready_out),  64'(e.ready));
        chk({tag, ".run"},        64'(run_out),        64'(e.run));
        chk({tag, ".busy"},       64'(busy_out),       64'(e.busy));
        chk({tag, ".done"},       64'(done_out),       64'(e.done));
        chk({tag, ".error"},      64'(error_out),      64'(e.err));
        chk({tag, ".addr"},       64'(config_addr_out), 64'(e.addr));
        chk({tag, ".data"},       64'(config_data_out), 64'(e.data));
        chk({tag, ".count"},      64'(cycle_count_out), 64'(e.cnt));
    endtask

    task automatic drive_idle();
        start_in      = 1'b0;
        abort_in      = 1'b0;
        cfg_valid_in  = 1'b0;
        cfg_last_in   = 1'b0;
        cfg_addr_in   = '0;
        cfg_data_in   = '0;
        max_cycles_in = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".cgra_reset"}, 64'(cgra_reset_out),  64'd0);
        chk({tag, ".ready"},      64'(cfg_ready_out),   64'd0);
        chk({tag, ".run"},        64'(run_out),         64'd0);
        chk({tag, ".busy"},       64'(busy_out),        64'd0);
        chk({tag, ".done"},       64'(done_out),        64'd0);
        chk({tag, ".error"},      64'(error_out),       64'd0);
        chk({tag, ".addr"},       64'(config_addr_out), 64'd0);
        chk({tag, ".data"},       64'(config_data_out), 64'd0);
        chk({tag, ".count"},      64'(cycle_count_out), 64'd0);
    endtask

    task automatic run_row(input int row, input vec_t v);
        int   c;
        int   ab;
        int   last_c;
        int   k;
        int   n_rst;
        int   n_run;
        int   n_done;
        exp_t e;
        string tag;

        m_xc.delete();
        m_addr.delete();
        m_data.delete();
        c = RST_C;
        for (int i = 0; i < v.nw; i++) begin
            c += (v.gapmax > 0) ? int'($urandom_range(v.gapmax)) : 0;
            m_xc.push_back(c);
            m_addr.push_back(($urandom_range(3) == 0) ? ADDR_W'(0) : ADDR_W'($urandom));
            m_data.push_back(DATA_W'($urandom));
            c++;
        end
        m_tlast   = (v.nw > 0) ? m_xc[v.nw-1] : RST_C - 1;
        m_timeout = !v.last;
        m_M       = v.maxc;
        m_tend    = m_tlast + TOUT;
        m_r0      = m_tlast + 2 + SETTLE_C;
        m_dd      = m_timeout ? (m_tend + 1) : (m_r0 + m_M);
        ab        = v.abort_at;
        if (v.abort_run >= 0) ab = m_r0 + v.abort_run;
        last_c    = ((ab >= 0) ? ab : m_dd) + 3;

        n_rst  = 0;
        n_run  = 0;
        n_done = 0;

        start_in      = 1'b1;
        max_cycles_in = CNT_W'(v.maxc);
        @(posedge clk_in); #1;

        for (c = 0; c <= last_c; c++) begin
            e = model_at(c);
            if (ab >= 0 && c > ab) begin
                e       = model_at(ab);
                e.rst   = 1'b0;
                e.ready = 1'b0;
                e.run   = 1'b0;
                e.busy  = 1'b0;
                e.done  = 1'b0;
                e.addr  = '0;
                e.data  = '0;
            end
            tag = $sformatf("row%0d.cyc%0d", row, c);
            check_outputs(tag, e);
            if (cgra_reset_out === 1'b1) n_rst++;
            if (run_out === 1'b1)        n_run++;
            if (done_out === 1'b1)       n_done++;

            cfg_valid_in = 1'b0;
            cfg_last_in  = 1'b0;
            cfg_addr_in  = '0;
            cfg_data_in  = '0;
            k = -1;
            foreach (m_xc[i]) if (m_xc[i] == c) k = i;
            if (k >= 0) begin
                cfg_valid_in = 1'b1;
                cfg_addr_in  = m_addr[k];
                cfg_data_in  = m_data[k];
                cfg_last_in  = v.last && (k == v.nw - 1);
            end else if (c < RST_C || (!m_timeout && c > m_tlast)) begin
                // Words offered outside LOAD must never reach the bus.
                cfg_valid_in = 1'($urandom_range(1));
                cfg_addr_in  = ADDR_W'($urandom) | ADDR_W'(1);
                cfg_data_in  = DATA_W'($urandom);
                cfg_last_in  = 1'($urandom_range(1));
            end
            if (c < m_dd && (ab < 0 || c < ab)) begin
                start_in      = 1'($urandom_range(1));
                max_cycles_in = CNT_W'($urandom);
            end else begin
                start_in      = 1'b0;
                max_cycles_in = '0;
            end
            abort_in = (c == ab);
            @(posedge clk_in); #1;
        end
        drive_idle();

        chk($sformatf("row%0d.rst_cycles", row),  64'(n_rst),  64'(v.exp_rst));
        chk($sformatf("row%0d.run_cycles", row),  64'(n_run),  64'(v.exp_run));
        chk($sformatf("row%0d.done_pulses", row), 64'(n_done), 64'(v.exp_done));
        chk($sformatf("row%0d.final_error", row), 64'(error_out), 64'(v.exp_err));
        chk($sformatf("row%0d.final_count", row), 64'(cycle_count_out), 64'(v.exp_cnt));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;

        // nw gap last max abort abort_run | rst run done err cnt
        vecs.push_back('{5, 0, 1'b1, 10,  -1, -1, 3, 10,  1, 1'b0, 10});  // nominal
        vecs.push_back('{8, 4, 1'b1, 6,   -1, -1, 3, 6,   1, 1'b0, 6});   // backpressure
        vecs.push_back('{2, 0, 1'b0, 7,   -1, -1, 3, 0,   1, 1'b1, 0});   // load timeout
        vecs.push_back('{5, 2, 1'b1, 9,    4, -1, 3, 0,   0, 1'b0, 0});   // abort in LOAD
        vecs.push_back('{3, 0, 1'b1, 12,  -1,  4, 3, 5,   0, 1'b0, 4});   // abort in RUN at 4
        vecs.push_back('{3, 1, 1'b1, 0,   -1, -1, 3, 0,   1, 1'b0, 0});   // max_cycles 0
        vecs.push_back('{1, 0, 1'b1, 3,   -1, -1, 3, 3,   1, 1'b0, 3});   // single word
        vecs.push_back('{2, 1, 1'b1, 255, -1, -1, 3, 255, 1, 1'b0, 255}); // all-ones count
        for (int r = 0; r < 6; r++) begin
            v.nw        = int'($urandom_range(10, 1));
            v.gapmax    = int'($urandom_range(4));
            v.last      = 1'b1;
            v.maxc      = int'($urandom_range(20));
            v.abort_at  = -1;
            v.abort_run = -1;
            v.exp_rst   = RST_C;
            v.exp_run   = v.maxc;
            v.exp_done  = 1;
            v.exp_err   = 1'b0;
            v.exp_cnt   = v.maxc;
            vecs.push_back(v);
        end

        // Reset with busy-looking inputs: everything must come up 0.
        drive_idle();
        reset_in      = 1'b0;
        start_in      = 1'b1;
        cfg_valid_in  = 1'b1;
        cfg_addr_in   = 16'h1234;
        max_cycles_in = 8'd5;
        repeat (3) @(posedge clk_in);
        #1;
        check_all_zero("reset");
        drive_idle();
        reset_in = 1'b1;
        @(posedge clk_in); #1;

        // Abort together with start in IDLE: abort wins.
        start_in      = 1'b1;
        abort_in      = 1'b1;
        max_cycles_in = 8'd4;
        @(posedge clk_in); #1;
        chk("idle_abort_start.busy",       64'(busy_out),       64'd0);
        chk("idle_abort_start.cgra_reset", 64'(cgra_reset_out), 64'd0);
        drive_idle();

        // A valid word in IDLE is refused and never reaches the bus.
        cfg_valid_in = 1'b1;
        cfg_addr_in  = 16'h0055;
        cfg_data_in  = 32'hDEADBEEF;
        chk("idle_valid.ready", 64'(cfg_ready_out), 64'd0);
        @(posedge clk_in); #1;
        chk("idle_valid.addr", 64'(config_addr_out), 64'd0);
        chk("idle_valid.data", 64'(config_data_out), 64'd0);
        drive_idle();
        @(posedge clk_in); #1;

        foreach (vecs[r]) begin
            run_row(r, vecs[r]);
            @(posedge clk_in); #1;
        end

        // Reset pulled low in the middle of RUN.
        start_in      = 1'b1;
        max_cycles_in = 8'd50;
        @(posedge clk_in); #1;
        start_in = 1'b0;
        for (int n = 0; n < 40 && run_out !== 1'b1; n++) begin
            cfg_valid_in = 1'b1;
            cfg_last_in  = 1'b1;
            cfg_addr_in  = 16'h00AB;
            cfg_data_in  = 32'h0000CAFE;
            @(posedge clk_in); #1;
        end
        drive_idle();
        chk("midrun.reached_run", 64'(run_out), 64'd1);
        repeat (3) @(posedge clk_in);
        #1;
        chk("midrun.count_before_reset", 64'(cycle_count_out), 64'd3);
        reset_in = 1'b0;
        @(posedge clk_in); #1;
        check_all_zero("midrun_reset");
        reset_in = 1'b1;
        @(posedge clk_in); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
